// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: byte/config request in, serial line and busy out.
// DATA_VALID is a request taken at a rising edge while busy is low (~busy acts as ready); nothing is queued.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] prescale;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Every bit lasts max(prescale,1) clocks; frame format and prescale are captured at accept.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   bus,
    output logic [2:0] state_dbg_o
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [PRESCALE_W-1:0] p_last_q, p_last_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic accept;
    logic bit_end;
    logic last_data;

    assign accept    = (state_q == S_IDLE) && bus.DATA_VALID;
    assign bit_end   = (edge_cnt_q == p_last_q);
    assign last_data = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));

    // State and datapath registers; reset forces the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            p_last_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            p_last_q   <= p_last_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        p_last_d   = p_last_q;

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    // Even parity is the XOR of the data; odd parity inverts it.
                    par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                    p_last_d  = (bus.prescale == '0) ? '0 : bus.prescale - PRESCALE_W'(1);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (last_data) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line value is decoded from the next state so the register always matches the state it enters.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign bus.TX_OUT  = tx_q;
    assign bus.busy    = busy_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: driver tasks push expected frames, a line monitor pops and checks them bit by bit.
module tb_uart_tx;

    localparam int EW = 21;  // {P[5:0], len[3:0], line bits[10:0]}

    logic       clk;
    logic       rst_n;
    logic [2:0] state_dbg;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];

    bit in_frame = 0;
    bit post     = 0;
    bit stray    = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model_frame(input logic [7:0] d, input logic pe,
                                                  input logic pt, input logic [5:0] ps);
        int          p;
        int          len;
        logic        par;
        logic [10:0] bits;
        p    = (ps == 0) ? 1 : int'(ps);
        par  = (($countones(d) % 2) == 1) ^ pt;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe) begin
            bits[9] = par;
            len = 11;
        end else begin
            len = 10;
        end
        return {6'(p), 4'(len), bits};
    endfunction

    function automatic int frame_cycles(input logic [EW-1:0] f);
        return int'(f[20:15]) * int'(f[14:11]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        wait_idle();
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.prescale   = ps;
        bus.DATA_VALID = 1'b1;
        exp_q.push_back(model_frame(d, pe, pt, ps));
        acc_q.push_back(cyc);
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL %s: tx=%b busy=%b state=%0d, required tx=1 busy=0 state=0",
                     name, bus.TX_OUT, bus.busy, state_dbg);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [EW-1:0] cur;
        int acc, p, len, bit_idx, cnt, fid;
        bit bit_ok;
        logic bad_tx, bad_busy;
        cur = '0; acc = 0; p = 1; len = 10; bit_idx = 0; cnt = 0; fid = 0;
        bit_ok = 1; bad_tx = 1'b1; bad_busy = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                post     = 0;
                stray    = 0;
            end else if (stray) begin
                if (bus.TX_OUT === 1'b1 && bus.busy === 1'b0) stray = 0;
            end else if (post) begin
                post = 0;
                checks++;
                if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL frame%0d idle_after: tx=%b busy=%b, required tx=1 busy=0",
                             fid, bus.TX_OUT, bus.busy);
                end
            end else if (!in_frame && bus.TX_OUT === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
                    stray = 1;
                end else begin
                    cur = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    fid++;
                    if (cyc != acc + 1) begin
                        errors++;
                        $display("FAIL frame%0d latency: start at cycle %0d, required %0d",
                                 fid, cyc, acc + 1);
                    end
                    p        = int'(cur[20:15]);
                    len      = int'(cur[14:11]);
                    in_frame = 1;
                    bit_idx  = 0;
                    cnt      = 0;
                    bit_ok   = 1;
                end
            end

            if (in_frame) begin
                if (bus.TX_OUT !== cur[bit_idx] || bus.busy !== 1'b1) begin
                    bit_ok   = 0;
                    bad_tx   = bus.TX_OUT;
                    bad_busy = bus.busy;
                end
                cnt++;
                if (cnt == p) begin
                    checks++;
                    if (!bit_ok) begin
                        errors++;
                        $display("FAIL frame%0d bit%0d: got tx=%b busy=%b, required tx=%b busy=1 for %0d cycles",
                                 fid, bit_idx, bad_tx, bad_busy, cur[bit_idx], p);
                    end
                    bit_ok = 1;
                    cnt    = 0;
                    bit_idx++;
                    if (bit_idx == len) begin
                        in_frame = 0;
                        post     = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        int acc1;
        logic [EW-1:0] f1;
        rst_n          = 1'b0;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.prescale   = 6'd1;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("idle_after_reset");

        // Basic frame, then mid-frame input changes and a dropped request.
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        repeat (10) @(negedge clk);
        bus.P_DATA     = 8'hFF;
        bus.prescale   = 6'd16;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;

        // Even and odd parity on the same byte.
        send(8'h03, 1'b1, 1'b0, 6'd4);
        send(8'h03, 1'b1, 1'b1, 6'd4);

        // Back-to-back with DATA_VALID held high.
        wait_idle();
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b1;
        bus.prescale   = 6'd1;
        bus.DATA_VALID = 1'b1;
        acc1 = cyc;
        f1   = model_frame(8'h55, 1'b1, 1'b1, 6'd1);
        exp_q.push_back(f1);
        acc_q.push_back(acc1);
        exp_q.push_back(model_frame(8'h0F, 1'b1, 1'b1, 6'd1));
        acc_q.push_back(acc1 + frame_cycles(f1) + 1);
        @(negedge clk);
        bus.P_DATA = 8'h0F;
        while (cyc < acc1 + frame_cycles(f1) + 1) @(negedge clk);
        @(negedge clk);
        bus.DATA_VALID = 1'b0;

        // Prescale 0 behaves as 1; maximum prescale.
        send(8'h96, 1'b0, 1'b0, 6'd0);
        send(8'h3C, 1'b1, 1'b1, 6'd63);

        // Reset in the middle of the data bits.
        send(8'hC3, 1'b0, 1'b0, 6'd4);
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check_idle("reset_mid_frame");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_after_abort");
        send(8'h5A, 1'b1, 1'b0, 6'd3);

        // Randomised frames.
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 10)));
        end

        n = 0;
        while ((exp_q.size() != 0 || in_frame || post) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL drain: %0d frames still expected, required 0", exp_q.size());
        end
        repeat (20) @(negedge clk);
        check_idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter; the transmit counterpart of the team's oversampling UART receiver.
- Accepts one parallel byte per handshake and serialises it on TX_OUT as: start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- Each bit is held for `prescale` clock cycles, so the receiver is fed at the same oversampling ratio it samples at.
- Frame format (parity enable/type) and prescale are captured per frame.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame
- PRESCALE_W, 6, width of prescale input

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- P_DATA  input  DATA_WIDTH  parallel byte to transmit
- DATA_VALID  input  1  request; P_DATA/config accepted when asserted while busy=0
- PAR_EN  input  1  1 = insert parity bit after data
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- prescale  input  PRESCALE_W  clock cycles per bit; 0 treated as 1
- TX_OUT  output  1  serial line, idle high (registered)
- busy  output  1  frame in progress (registered)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, TX_OUT=1, busy=0, edge and bit counters=0, shift register=0. Reset mid-frame aborts immediately; line returns high.
- Accept: at a rising edge with state=IDLE and DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYP and prescale (P = max(prescale,1)). Compute and latch parity: even = XOR(P_DATA); odd = ~XOR(P_DATA). At the same edge go to START, with TX_OUT<=0 and busy<=1.
- Latency: TX_OUT falls exactly 1 cycle after the accepting edge. DATA_VALID while busy=1 is ignored; no queueing.
- Inputs sampled only at accept. Changes to P_DATA/PAR_EN/PAR_TYP/prescale mid-frame do not affect the current frame.
- Edge counter counts 0..P-1 within each bit. A bit ends when edge_cnt==P-1; edge_cnt then wraps to 0.
- FSM states and transitions:
  - IDLE: TX_OUT=1; go to START on accept.
  - START: TX_OUT=0 for P cycles; then go to DATA, bit_cnt=0.
  - DATA: TX_OUT=data[bit_cnt], LSB first. After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT=latched parity bit for P cycles; then go to STOP.
  - STOP: TX_OUT=1 for P cycles; then go to IDLE with busy<=0.
- Frame length: busy high for exactly (10+PAR_EN)*P cycles (DATA_WIDTH=8). TX_OUT is glitch-free because it comes straight from a register.
- Back-to-back: with DATA_VALID held high, the next accept happens in the first IDLE cycle. Consecutive frames are therefore separated by exactly 1 extra idle-high cycle beyond the stop bit.
- P=1: each bit lasts 1 cycle, with no counter wrap issues. P=63: max width, no overflow (edge counter is PRESCALE_W bits).

Test Plan:
- Reset during frame: assert rst_n=0 mid-DATA -> TX_OUT=1 and busy=0 asynchronously. After release, an idle line and a new frame start cleanly.
- Basic frame, no parity: P_DATA=0xA5, PAR_EN=0, prescale=8, single-cycle DATA_VALID -> TX_OUT low 1 cycle later. Line sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; busy high 80 cycles.
- Even parity: P_DATA=0x03, PAR_EN=1, PAR_TYP=0, prescale=4 -> parity bit 0; frame 44 cycles. Same byte with PAR_TYP=1 -> parity bit 1.
- Mid-frame changes: change P_DATA to 0xFF and prescale to 16 during the frame, and pulse DATA_VALID -> current frame is unchanged (original data, 8 cycles/bit) and the extra request is dropped.
- Back-to-back: DATA_VALID held, P_DATA=0x55 then 0x0F, prescale=1, PAR_EN=1, PAR_TYP=1 -> two 11-cycle frames with parity 1 and 1, separated by one idle-high cycle.
- prescale=0 -> behaves as prescale=1 (10-cycle frame, no parity).
